stopwatch_key_ctrl: RTL and testbench

//  Key-action sequencer for the stop watch counter/display datapath. Conditions three

---
 rtl/stopwatch_key_ctrl_if.sv | 21 ++
 rtl/stopwatch_key_ctrl.sv | 149 ++++++++++++++
 tb/tb_stopwatch_key_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_key_ctrl_if.sv
// Key inputs and control outputs between the board/tb side and the stopwatch key sequencer.
// Keys are raw active-low levels; outputs are single-bit controls plus a one-hot LED vector.
interface stopwatch_key_ctrl_if;
    logic       key_start;
    logic       key_lap;
    logic       key_clear;
    logic       tick;
    logic       count_clr;
    logic       display_en;
    logic [3:0] led;

    modport master (
        output key_start, key_lap, key_clear,
        input  tick, count_clr, display_en, led
    );

    modport slave (
        input  key_start, key_lap, key_clear,
        output tick, count_clr, display_en, led
    );
endinterface

// File: rtl/stopwatch_key_ctrl.sv
// Purpose: debounces three active-low keys and sequences IDLE/RUN/PAUSE/LAP with a count tick.
// Latency: stable key edge to state/output change is DEBOUNCE_CYCLES+3 clk edges.
// Backpressure: none; keys are levels and all outputs are free-running controls.
module stopwatch_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_key_ctrl_if.slave  bus
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TDW-1:0] TD_LAST = TDW'(TICK_DIV - 1);

    // Key index: 0 = start, 1 = lap, 2 = clear
    localparam int K_START = 0;
    localparam int K_LAP   = 1;
    localparam int K_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    logic [2:0]     key_raw;
    logic [2:0]     sync1_q, sync1_d;
    logic [2:0]     sync2_q, sync2_d;
    logic [2:0]     lvl_q, lvl_d;
    logic [2:0]     press_q, press_d;
    logic [DBW-1:0] cnt_q [3];
    logic [DBW-1:0] cnt_d [3];

    state_t         state_q, state_d;
    logic           clr_q, clr_d;
    logic [TDW-1:0] div_q, div_d;
    logic           counting;

    assign key_raw = {bus.key_clear, bus.key_lap, bus.key_start};

    // Key conditioning: sync, then accept a new level only after it has differed long enough.
    // The press pulse is registered on the same edge the accepted level falls.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        press_d = '0;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sync2_q[k] == lvl_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DB_LAST) begin
                lvl_d[k]   = ~lvl_q[k];
                cnt_d[k]   = '0;
                press_d[k] = lvl_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            lvl_q   <= 3'b111;
            press_q <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);

    // Clear wins over start, start over lap; lower-priority presses in the same cycle are dropped.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (press_q[K_CLEAR]) begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
        end else if (press_q[K_START]) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_LAP:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end else if (press_q[K_LAP]) begin
            case (state_q)
                S_RUN:   state_d = S_LAP;
                S_LAP:   state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Divider keeps its partial period through PAUSE so a resume does not restart the 10 ms slot.
    always_comb begin
        div_d = div_q;
        if (state_d == S_IDLE) begin
            div_d = '0;
        end else if (counting) begin
            div_d = (div_q == TD_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            div_q   <= div_d;
        end
    end

    assign bus.tick       = counting && (div_q == TD_LAST);
    assign bus.count_clr  = clr_q;
    assign bus.display_en = (state_q != S_LAP);

    always_comb begin
        bus.led = 4'b0001;
        case (state_q)
            S_IDLE:  bus.led = 4'b0001;
            S_RUN:   bus.led = 4'b0010;
            S_PAUSE: bus.led = 4'b0100;
            S_LAP:   bus.led = 4'b1000;
            default: bus.led = 4'b0001;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Bench for stopwatch_key_ctrl: directed key sequences, a key/FSM/tick model checked every cycle,
// and hand-computed literal expectations at the interesting points.
module tb_stopwatch_key_ctrl;

    localparam int D = 4;
    localparam int T = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] keys  = 3'b111;

    always #5 clk = ~clk;

    stopwatch_key_ctrl_if bus ();
    assign bus.key_start = keys[0];
    assign bus.key_lap   = keys[1];
    assign bus.key_clear = keys[2];

    stopwatch_key_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a key press lands when the raw level has stayed away from the accepted level
    // for D sampled edges; it acts on the FSM 3 edges later (synchroniser plus press register).
    int m_state = 0;           // 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
    int m_phase = 0;           // counting cycles elapsed modulo T
    bit m_clr   = 1'b0;
    bit m_acc [3] = '{1'b1, 1'b1, 1'b1};
    int m_run [3] = '{0, 0, 0};
    int m_due [3] = '{-1, -1, -1};
    int m_edge  = 0;
    bit m_ps, m_pl, m_pc, m_was_cnt;
    int m_nxt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_phase = 0;
            m_clr   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 1'b1;
                m_run[k] = 0;
                m_due[k] = -1;
            end
        end else begin
            m_edge++;
            m_ps = (m_due[0] == m_edge);
            m_pl = (m_due[1] == m_edge);
            m_pc = (m_due[2] == m_edge);
            m_was_cnt = (m_state == 1) || (m_state == 3);
            m_nxt = m_state;
            if (m_pc)                         m_nxt = 0;
            else if (m_ps)                    m_nxt = m_was_cnt ? 2 : 1;
            else if (m_pl && m_state == 1)    m_nxt = 3;
            else if (m_pl && m_state == 3)    m_nxt = 1;
            m_clr = m_pc;
            if (m_nxt == 0)     m_phase = 0;
            else if (m_was_cnt) m_phase = (m_phase + 1) % T;
            m_state = m_nxt;
            for (int k = 0; k < 3; k++) begin
                if (keys[k] != m_acc[k]) m_run[k]++;
                else                     m_run[k] = 0;
                if (m_run[k] == D) begin
                    m_acc[k] = keys[k];
                    m_run[k] = 0;
                    if (!keys[k]) m_due[k] = m_edge + 3;
                end
            end
        end
    end

    int tick_cnt   = 0;
    int clr_cnt    = 0;
    bit pause_seen = 1'b0;
    logic [3:0] exp_led;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_led = 4'b0001 << m_state;
            check("model_led", {4'b0, bus.led}, {4'b0, exp_led});
            check("model_display_en", {7'b0, bus.display_en}, {7'b0, m_state != 3});
            check("model_tick", {7'b0, bus.tick},
                  {7'b0, ((m_state == 1) || (m_state == 3)) && (m_phase == T - 1)});
            check("model_count_clr", {7'b0, bus.count_clr}, {7'b0, m_clr});
            if (bus.tick)           tick_cnt++;
            if (bus.count_clr)      clr_cnt++;
            if (bus.led == 4'b0100) pause_seen = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_key(input int k);
        keys[k] = 1'b0;
        cyc(10);
        keys[k] = 1'b1;
        cyc(10);
    endtask

    initial begin
        // 1: reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_led", {4'b0, bus.led}, 8'h01);
        check("rst_display_en", {7'b0, bus.display_en}, 8'h01);
        check("rst_tick", {7'b0, bus.tick}, 8'h00);
        check("rst_count_clr", {7'b0, bus.count_clr}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        tick_cnt = 0;
        cyc(100);
        check("idle_ticks", 8'(tick_cnt), 8'd0);
        check("idle_led", {4'b0, bus.led}, 8'h01);

        // 2: start latency, tick cadence, pause holds divider
        keys[0] = 1'b0;
        cyc(6);
        check("start_edge6_led", {4'b0, bus.led}, 8'h01);
        cyc(1);
        check("start_edge7_led", {4'b0, bus.led}, 8'h02);
        cyc(3);
        check("run_tick_c3", {7'b0, bus.tick}, 8'h00);
        cyc(1);
        check("run_tick_c4", {7'b0, bus.tick}, 8'h01);
        cyc(1);
        check("run_tick_c5", {7'b0, bus.tick}, 8'h00);
        keys[0] = 1'b1;
        cyc(10);
        press_key(0);
        check("pause_led", {4'b0, bus.led}, 8'h04);
        tick_cnt = 0;
        cyc(20);
        check("pause_ticks", 8'(tick_cnt), 8'd0);
        press_key(0);
        check("resume_led", {4'b0, bus.led}, 8'h02);

        // 3: lap freezes display, ticks continue
        press_key(1);
        check("lap_led", {4'b0, bus.led}, 8'h08);
        check("lap_display_en", {7'b0, bus.display_en}, 8'h00);
        tick_cnt = 0;
        cyc(10);
        check("lap_ticks", 8'(tick_cnt), 8'd2);
        press_key(1);
        check("unlap_led", {4'b0, bus.led}, 8'h02);
        check("unlap_display_en", {7'b0, bus.display_en}, 8'h01);

        // 4: short glitch is rejected
        keys[0] = 1'b0;
        cyc(3);
        keys[0] = 1'b1;
        cyc(12);
        check("glitch_led", {4'b0, bus.led}, 8'h02);

        // 5: start and clear together, clear wins; clear again while idle
        clr_cnt = 0;
        pause_seen = 1'b0;
        keys = 3'b010;
        cyc(10);
        keys = 3'b111;
        cyc(10);
        check("clr_led", {4'b0, bus.led}, 8'h01);
        check("clr_pulses", 8'(clr_cnt), 8'd1);
        check("clr_no_pause", {7'b0, pause_seen}, 8'h00);
        press_key(2);
        check("idle_clr_pulses", 8'(clr_cnt), 8'd2);
        check("idle_clr_led", {4'b0, bus.led}, 8'h01);

        keys[0] = 1'b0;
        cyc(7);
        check("rerun_led", {4'b0, bus.led}, 8'h02);
        cyc(3);
        check("rerun_tick_c3", {7'b0, bus.tick}, 8'h00);
        cyc(1);
        check("rerun_tick_c4", {7'b0, bus.tick}, 8'h01);

        // 6: asynchronous reset in the middle of a tick period
        cyc(3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_led", {4'b0, bus.led}, 8'h01);
        check("arst_tick", {7'b0, bus.tick}, 8'h00);
        check("arst_display_en", {7'b0, bus.display_en}, 8'h01);
        check("arst_count_clr", {7'b0, bus.count_clr}, 8'h00);
        keys = 3'b111;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        check("post_rst_led", {4'b0, bus.led}, 8'h01);
        keys[0] = 1'b0;
        cyc(7);
        check("post_rst_run_led", {4'b0, bus.led}, 8'h02);
        cyc(3);
        check("post_rst_tick_c3", {7'b0, bus.tick}, 8'h00);
        cyc(1);
        check("post_rst_tick_c4", {7'b0, bus.tick}, 8'h01);
        keys = 3'b111;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
